entry_sequencer: RTL and testbench

- Front-panel controller that sequences numeric entry and result display.
- In INPUT mode, collects one-cycle key events into a DIGITS-wide BCD buffer with backspace and clear.
- On a state_switch pulse, hands the buffer to the downstream compute/display datapath over a valid/ready handshake, then holds DISPLAY mode.
- Replaces the bare two-state mode toggle; mode output keeps the existing encoding: 1 = input, 0 = display.

---
 rtl/entry_seq_pkg.sv | 23 ++
 rtl/entry_sequencer_cycle_timer.sv | 37 +++
 rtl/entry_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_entry_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/entry_seq_pkg.sv
// Shared definitions for the entry sequencer: FSM state encodings, the
// special key codes and the mode output values.
package entry_seq_pkg;

  typedef enum logic [1:0] {
    ST_INPUT   = 2'd0,
    ST_COMMIT  = 2'd1,
    ST_DISPLAY = 2'd2
  } state_t;

  localparam logic [3:0] KEY_BS    = 4'hA;
  localparam logic [3:0] KEY_CLR   = 4'hB;
  localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;

  localparam logic MODE_INPUT   = 1'b1;
  localparam logic MODE_DISPLAY = 1'b0;

  // True for key codes 0-9, which enter a digit into the buffer.
  function automatic logic is_digit_key(input logic [3:0] code);
    return code <= KEY_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/entry_sequencer_cycle_timer.sv
// cycle_timer: counts enabled cycles from 0 up to LIMIT-1 and wraps.
// expire is high during the cycle in which the count sits at LIMIT-1 with
// en asserted, so a consumer registering on it acts exactly LIMIT enabled
// cycles after the last clr.
module cycle_timer #(
  parameter int LIMIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count_reg;

  assign expire = en && (count_reg == LAST);

  // Count enabled cycles; clr has priority and restarts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      if (count_reg == LAST) begin
        count_reg <= '0;
      end else begin
        count_reg <= count_reg + CW'(1);
      end
    end
  end

endmodule

// File: rtl/entry_sequencer.sv
// entry_sequencer: front-panel entry controller. Collects BCD digits in
// INPUT mode, hands the buffer downstream over valid/ready in COMMIT, then
// holds DISPLAY until state_switch or the optional display timeout.
// Optional build macro: CURSOR_BLINK_EN (blinking "0" at the cursor digit).
module entry_sequencer
  import entry_seq_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int TIMEOUT_CYC = 0,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        key_valid,
  input  logic [3:0]                  key_code,
  input  logic                        state_switch,
  input  logic                        commit_ready,
  output logic                        commit_valid,
  output logic [4*DIGITS-1:0]         commit_data,
  output logic [4*DIGITS-1:0]         digits,
  output logic [$clog2(DIGITS+1)-1:0] digit_cnt,
  output logic                        mode,
  output logic [DIGITS-1:0]           blank
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);
  // Reset shows a single "0" in the rightmost digit.
  localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

  state_t          state_reg, state_next;
  logic [W-1:0]    digits_reg, digits_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            commit_valid_reg, commit_valid_next;
  logic [W-1:0]    commit_data_reg, commit_data_next;
  logic            mode_reg;
  logic [DIGITS-1:0] blank_reg, blank_next, blank_input;

  logic timeout_expire;
  logic cursor_on;

  // ---------------------------------------------------------------------
  // DISPLAY timeout: timer held clear outside DISPLAY, so it starts from
  // zero on the entry edge and fires after exactly TIMEOUT_CYC cycles.
  // ---------------------------------------------------------------------
  generate
    if (TIMEOUT_CYC > 0) begin : g_timeout
      cycle_timer #(
        .LIMIT (TIMEOUT_CYC)
      ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_reg != ST_DISPLAY),
        .en     (state_reg == ST_DISPLAY),
        .expire (timeout_expire)
      );
    end else begin : g_no_timeout
      assign timeout_expire = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Cursor blink phase (optional).
  // ---------------------------------------------------------------------
`ifdef CURSOR_BLINK_EN
  logic blink_expire;
  logic blink_phase_reg, blink_phase_next;

  // Free-running; any key event restarts the half-period.
  cycle_timer #(
    .LIMIT (BLINK_DIV)
  ) u_blink (
    .clk    (clk),
    .rst    (rst),
    .clr    (key_valid),
    .en     (1'b1),
    .expire (blink_expire)
  );

  // A key forces the on-phase; otherwise toggle at each half-period.
  always_comb begin
    blink_phase_next = blink_phase_reg;
    if (key_valid) begin
      blink_phase_next = 1'b1;
    end else if (blink_expire) begin
      blink_phase_next = ~blink_phase_reg;
    end
  end

  // Blink phase register; starts in the on-phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_phase_reg <= 1'b1;
    end else begin
      blink_phase_reg <= blink_phase_next;
    end
  end

  assign cursor_on = blink_phase_next && (cnt_next < CNT_FULL);
`else
  // No blink: the cursor position is never forced visible.
  assign cursor_on = 1'b0 & (BLINK_DIV != 0);
`endif

  // ---------------------------------------------------------------------
  // INPUT-mode blank mask computed from the next digit count so that the
  // registered mask lines up with the registered buffer. Digit 0 is never
  // blanked: with no entry it shows "0".
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
      if (gi == 0) begin : g_first
        assign blank_input[gi] = 1'b0;
      end else begin : g_rest
        assign blank_input[gi] = (CW'(gi) >= cnt_next)
                                 && !(cursor_on && (cnt_next == CW'(gi)));
      end
    end
  endgenerate

  // Next-state and next-buffer logic for the sequencer FSM.
  always_comb begin
    state_next        = state_reg;
    digits_next       = digits_reg;
    cnt_next          = cnt_reg;
    commit_valid_next = commit_valid_reg;
    commit_data_next  = commit_data_reg;

    case (state_reg)
      ST_INPUT: begin
        if (state_switch) begin
          // Switch wins over a coincident key; snapshot the current buffer.
          state_next        = ST_COMMIT;
          commit_valid_next = 1'b1;
          commit_data_next  = digits_reg;
        end else if (key_valid) begin
          if (is_digit_key(key_code)) begin
            if (cnt_reg < CNT_FULL) begin
              digits_next = (digits_reg << 4) | W'(key_code);
              cnt_next    = cnt_reg + CW'(1);
            end
          end else if (key_code == KEY_BS) begin
            if (cnt_reg != '0) begin
              digits_next = digits_reg >> 4;
              cnt_next    = cnt_reg - CW'(1);
            end
          end else if (key_code == KEY_CLR) begin
            digits_next = '0;
            cnt_next    = '0;
          end
        end
      end

      ST_COMMIT: begin
        // Hold the offer until downstream takes it.
        if (commit_valid_reg && commit_ready) begin
          state_next        = ST_DISPLAY;
          commit_valid_next = 1'b0;
        end
      end

      ST_DISPLAY: begin
        // Manual return and timeout both land in a cleared INPUT.
        if (state_switch || timeout_expire) begin
          state_next  = ST_INPUT;
          digits_next = '0;
          cnt_next    = '0;
        end
      end

      default: begin
        state_next        = ST_INPUT;
        digits_next       = '0;
        cnt_next          = '0;
        commit_valid_next = 1'b0;
      end
    endcase

    blank_next = (state_next == ST_INPUT) ? blank_input : '0;
  end

  // State and registered outputs; reset also drops any pending commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_INPUT;
      digits_reg       <= '0;
      cnt_reg          <= '0;
      commit_valid_reg <= 1'b0;
      commit_data_reg  <= '0;
      mode_reg         <= MODE_INPUT;
      blank_reg        <= BLANK_RST;
    end else begin
      state_reg        <= state_next;
      digits_reg       <= digits_next;
      cnt_reg          <= cnt_next;
      commit_valid_reg <= commit_valid_next;
      commit_data_reg  <= commit_data_next;
      mode_reg         <= (state_next == ST_INPUT) ? MODE_INPUT : MODE_DISPLAY;
      blank_reg        <= blank_next;
    end
  end

  assign commit_valid = commit_valid_reg;
  assign commit_data  = commit_data_reg;
  assign digits       = digits_reg;
  assign digit_cnt    = cnt_reg;
  assign mode         = mode_reg;
  assign blank        = blank_reg;

endmodule

// File: tb/tb_entry_sequencer.sv
// Directed testbench for entry_sequencer (DIGITS=4, TIMEOUT_CYC=10).
module tb_entry_sequencer;

  logic        clk;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        state_switch;
  logic        commit_ready;
  logic        commit_valid;
  logic [15:0] commit_data;
  logic [15:0] digits;
  logic [2:0]  digit_cnt;
  logic        mode;
  logic [3:0]  blank;

  int n_assert = 0;
  int n_fail   = 0;

  entry_sequencer #(
    .DIGITS      (4),
    .TIMEOUT_CYC (10),
    .BLINK_DIV   (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .state_switch (state_switch),
    .commit_ready (commit_ready),
    .commit_valid (commit_valid),
    .commit_data  (commit_data),
    .digits       (digits),
    .digit_cnt    (digit_cnt),
    .mode         (mode),
    .blank        (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    tick();
    key_valid = 1'b0;
    $display("key %h -> digits=%h cnt=%0d blank=%b mode=%b", code, digits, digit_cnt, blank, mode);
  endtask

  task automatic switch_pulse();
    state_switch = 1'b1;
    tick();
    state_switch = 1'b0;
    $display("switch -> mode=%b cv=%b cd=%h digits=%h", mode, commit_valid, commit_data, digits);
  endtask

  initial begin
    rst          = 1'b1;
    key_valid    = 1'b0;
    key_code     = 4'h0;
    state_switch = 1'b0;
    commit_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_cnt", 32'(digit_cnt), 32'd0);
    chk("rst_cv", 32'(commit_valid), 32'd0);
    chk("rst_cd", 32'(commit_data), 32'h0);
    chk("rst_mode", 32'(mode), 32'd1);
    chk("rst_blank", 32'(blank), 32'b1110);
    rst = 1'b0;
    tick();

    // Keys 1,2,3
    press(4'd1); press(4'd2); press(4'd3);
    chk("k123_digits", 32'(digits), 32'h0123);
    chk("k123_cnt", 32'(digit_cnt), 32'd3);
    chk("k123_blank", 32'(blank), 32'b1000);
    chk("k123_mode", 32'(mode), 32'd1);

    // Fill, overflow key ignored
    press(4'd4); press(4'd5);
    chk("full_digits", 32'(digits), 32'h1234);
    chk("full_cnt", 32'(digit_cnt), 32'd4);
    chk("full_blank", 32'(blank), 32'b0000);
    press(4'hA);
    chk("bs_digits", 32'(digits), 32'h0123);
    chk("bs_cnt", 32'(digit_cnt), 32'd3);
    press(4'hB);
    chk("clr_digits", 32'(digits), 32'h0);
    chk("clr_cnt", 32'(digit_cnt), 32'd0);
    chk("clr_blank", 32'(blank), 32'b1110);
    press(4'hA);
    chk("bs_empty_cnt", 32'(digit_cnt), 32'd0);
    chk("bs_empty_digits", 32'(digits), 32'h0);
    press(4'hE);
    chk("ign_key_digits", 32'(digits), 32'h0);

    // Commit with back-pressure
    press(4'd4); press(4'd2);
    chk("b42_digits", 32'(digits), 32'h0042);
    switch_pulse();
    chk("c1_cv", 32'(commit_valid), 32'd1);
    chk("c1_cd", 32'(commit_data), 32'h0042);
    chk("c1_mode", 32'(mode), 32'd0);
    chk("c1_blank", 32'(blank), 32'b0000);
    press(4'd9);
    chk("c2_cv", 32'(commit_valid), 32'd1);
    chk("c2_digits", 32'(digits), 32'h0042);
    switch_pulse();
    chk("c3_cv", 32'(commit_valid), 32'd1);
    chk("c3_mode", 32'(mode), 32'd0);
    tick();
    chk("c4_cv", 32'(commit_valid), 32'd1);
    chk("c4_cd", 32'(commit_data), 32'h0042);
    commit_ready = 1'b1;
    tick();
    commit_ready = 1'b0;
    $display("handshake -> cv=%b mode=%b", commit_valid, mode);
    chk("hs_cv", 32'(commit_valid), 32'd0);
    chk("hs_mode", 32'(mode), 32'd0);
    chk("hs_digits", 32'(digits), 32'h0042);

    // DISPLAY ignores keys, switch returns to cleared INPUT
    press(4'd5);
    chk("disp_key_digits", 32'(digits), 32'h0042);
    chk("disp_key_mode", 32'(mode), 32'd0);
    switch_pulse();
    chk("ret_mode", 32'(mode), 32'd1);
    chk("ret_digits", 32'(digits), 32'h0);
    chk("ret_cnt", 32'(digit_cnt), 32'd0);
    chk("ret_blank", 32'(blank), 32'b1110);

    // Switch and key in the same cycle: key dropped
    press(4'd6);
    key_valid = 1'b1;
    key_code  = 4'd7;
    switch_pulse();
    key_valid = 1'b0;
    chk("sk_cd", 32'(commit_data), 32'h0006);
    chk("sk_digits", 32'(digits), 32'h0006);
    chk("sk_cv", 32'(commit_valid), 32'd1);
    commit_ready = 1'b1;
    tick();
    commit_ready = 1'b0;
    chk("sk_hs_cv", 32'(commit_valid), 32'd0);

    // Timeout: DISPLAY entered on the previous edge, leave after 10 cycles
    repeat (9) tick();
    $display("display +9 -> mode=%b digits=%h", mode, digits);
    chk("to9_mode", 32'(mode), 32'd0);
    chk("to9_digits", 32'(digits), 32'h0006);
    tick();
    $display("display +10 -> mode=%b digits=%h", mode, digits);
    chk("to10_mode", 32'(mode), 32'd1);
    chk("to10_digits", 32'(digits), 32'h0);
    chk("to10_cnt", 32'(digit_cnt), 32'd0);

    // Reset mid-COMMIT
    press(4'd3);
    switch_pulse();
    chk("rc_cv_before", 32'(commit_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    $display("async rst -> cv=%b mode=%b", commit_valid, mode);
    chk("rc_cv_async", 32'(commit_valid), 32'd0);
    chk("rc_mode_async", 32'(mode), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    chk("rc_digits", 32'(digits), 32'h0);
    chk("rc_cnt", 32'(digit_cnt), 32'd0);
    chk("rc_cd", 32'(commit_data), 32'h0);
    press(4'd8);
    chk("rc_key_digits", 32'(digits), 32'h0008);
    chk("rc_key_cnt", 32'(digit_cnt), 32'd1);
    chk("rc_key_blank", 32'(blank), 32'b1110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
